// File: rtl/intm_rs.sv
// Reservation station for RV32M multiply/divide uops: a compacting age queue that
// wakes sources from CDB broadcasts and issues the oldest fully-ready entry.
module intm_rs #(
  parameter int NUM_ENTRIES = 4,
  parameter int PRF_IDX_W   = 6,
  parameter int ROB_IDX_W   = 5,
  parameter int CDB_PORTS   = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           dis_valid,
  output logic                           dis_ready,
  input  logic [2:0]                     dis_op,
  input  logic [PRF_IDX_W-1:0]           dis_ps1,
  input  logic                           dis_ps1_rdy,
  input  logic [PRF_IDX_W-1:0]           dis_ps2,
  input  logic                           dis_ps2_rdy,
  input  logic [PRF_IDX_W-1:0]           dis_pd,
  input  logic [ROB_IDX_W-1:0]           dis_rob_id,
  input  logic [CDB_PORTS-1:0]           cdb_valid,
  input  logic [CDB_PORTS*PRF_IDX_W-1:0] cdb_pd,
  output logic                           iss_valid,
  input  logic                           iss_ready,
  output logic [2:0]                     iss_op,
  output logic [PRF_IDX_W-1:0]           iss_ps1,
  output logic [PRF_IDX_W-1:0]           iss_ps2,
  output logic [PRF_IDX_W-1:0]           iss_pd,
  output logic [ROB_IDX_W-1:0]           iss_rob_id,
  output logic [$clog2(NUM_ENTRIES+1)-1:0] count
);

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int CNT_W = $clog2(NUM_ENTRIES+1);

  typedef struct packed {
    logic                 valid;
    logic [2:0]           op;
    logic [PRF_IDX_W-1:0] ps1;
    logic                 rdy1;
    logic [PRF_IDX_W-1:0] ps2;
    logic                 rdy2;
    logic [PRF_IDX_W-1:0] pd;
    logic [ROB_IDX_W-1:0] rob_id;
  } slot_t;

  slot_t            slots_q [NUM_ENTRIES];
  slot_t            woke    [NUM_ENTRIES];
  slot_t            slots_d [NUM_ENTRIES];
  slot_t            new_slot;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] wr_pos;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic             dis_fire;
  logic             iss_fire;

  function automatic logic cdb_hit(input logic [PRF_IDX_W-1:0]           tag,
                                   input logic [CDB_PORTS-1:0]           v,
                                   input logic [CDB_PORTS*PRF_IDX_W-1:0] pds);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < CDB_PORTS; k++) begin
      hit = hit | (v[k] && (pds[k*PRF_IDX_W +: PRF_IDX_W] == tag));
    end
    return hit;
  endfunction

  // Handshakes: a transfer happens on a cycle where valid && ready are both high
  // at the rising edge; valid never depends on ready, and dis_ready depends only
  // on registered occupancy.
  assign dis_ready = (count_q < CNT_W'(NUM_ENTRIES));
  assign dis_fire  = dis_valid && dis_ready;
  assign iss_fire  = iss_valid && iss_ready;
  assign count     = count_q;

  // Descending scan so the lowest (oldest) ready slot wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
      if (slots_q[i].valid && slots_q[i].rdy1 && slots_q[i].rdy2) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    iss_valid  = sel_found;
    iss_op     = '0;
    iss_ps1    = '0;
    iss_ps2    = '0;
    iss_pd     = '0;
    iss_rob_id = '0;
    if (sel_found) begin
      iss_op     = slots_q[sel_idx].op;
      iss_ps1    = slots_q[sel_idx].ps1;
      iss_ps2    = slots_q[sel_idx].ps2;
      iss_pd     = slots_q[sel_idx].pd;
      iss_rob_id = slots_q[sel_idx].rob_id;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      woke[i] = slots_q[i];
      if (cdb_hit(slots_q[i].ps1, cdb_valid, cdb_pd)) woke[i].rdy1 = 1'b1;
      if (cdb_hit(slots_q[i].ps2, cdb_valid, cdb_pd)) woke[i].rdy2 = 1'b1;
    end
  end

  // Tag 0 is x0 and is always available; a same-cycle broadcast is bypassed in.
  always_comb begin
    new_slot        = '0;
    new_slot.valid  = 1'b1;
    new_slot.op     = dis_op;
    new_slot.ps1    = dis_ps1;
    new_slot.rdy1   = dis_ps1_rdy || (dis_ps1 == '0) || cdb_hit(dis_ps1, cdb_valid, cdb_pd);
    new_slot.ps2    = dis_ps2;
    new_slot.rdy2   = dis_ps2_rdy || (dis_ps2 == '0) || cdb_hit(dis_ps2, cdb_valid, cdb_pd);
    new_slot.pd     = dis_pd;
    new_slot.rob_id = dis_rob_id;
  end

  assign wr_pos = count_q - CNT_W'(iss_fire);

  // Slots at or above the issued one take their younger neighbour's (woken) value.
  always_comb begin
    for (int j = 0; j < NUM_ENTRIES; j++) begin
      slots_d[j] = woke[j];
      if (iss_fire && (IDX_W'(j) >= sel_idx)) begin
        if (j == NUM_ENTRIES-1) slots_d[j] = '0;
        else                    slots_d[j] = woke[(j+1) % NUM_ENTRIES];
      end
      if (dis_fire && (CNT_W'(j) == wr_pos)) slots_d[j] = new_slot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) slots_q[i] <= '0;
    end else if (flush) begin
      count_q <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) slots_q[i] <= '0;
    end else begin
      count_q <= count_q + CNT_W'(dis_fire) - CNT_W'(iss_fire);
      for (int i = 0; i < NUM_ENTRIES; i++) slots_q[i] <= slots_d[i];
    end
  end

endmodule
